// File: rtl/cpu_perf_pkg.sv
// Shared types and constants for the CPU performance monitor.
// States, halt sentinel default and the trace-entry layout.
package cpu_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    localparam logic [31:0] END_SENTINEL_DEF = 32'h0000_006F;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        misalign;
    } trc_entry_t;

    function automatic logic is_misaligned(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/cpu_perf_if.sv
// Store-trace stream handshake between the monitor and its consumer.
// The monitor is the master (drives valid/payload, samples ready).
interface cpu_perf_if;

    logic        trc_valid;
    logic        trc_ready;
    logic [31:0] trc_addr;
    logic [31:0] trc_data;
    logic        trc_misalign;

    modport master (
        output trc_valid,
        output trc_addr,
        output trc_data,
        output trc_misalign,
        input  trc_ready
    );

    modport slave (
        input  trc_valid,
        input  trc_addr,
        input  trc_data,
        input  trc_misalign,
        output trc_ready
    );

endinterface

// File: rtl/cpu_perf_fifo.sv
// First-word-fall-through FIFO with synchronous clear.
// A push while full is accepted only when a pop frees the slot that edge.
module cpu_perf_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign w_do_pop  = i_pop & ~o_empty & ~i_clr;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_clr;

    assign o_data = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/cpu_perf_monitor.sv
// Retire/store performance monitor with bounded run and store-trace FIFO.
// Define CPU_PERF_MISALIGN_EN to enable misaligned-store flagging and counting.
module cpu_perf_monitor
    import cpu_perf_pkg::*;
#(
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned TRACE_DEPTH  = 8,
    parameter int unsigned MAX_CYCLES   = 20,
    parameter logic [31:0] END_SENTINEL = END_SENTINEL_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 retire_valid,
    input  logic [31:0]          retire_pc,
    input  logic [31:0]          retire_instr,
    input  logic                 mem_write,
    input  logic [31:0]          dmem_addr,
    input  logic [31:0]          store_data,
    cpu_perf_if.master           trc,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [CNT_WIDTH-1:0] store_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic [CNT_WIDTH-1:0] misalign_count,
    output logic [31:0]          end_pc,
    output logic [1:0]           state,
    output logic                 done,
    output logic                 timeout,
    output logic                 overflow
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cyc;
    logic [CNT_WIDTH-1:0] r_instr;
    logic [CNT_WIDTH-1:0] r_store;
    logic [CNT_WIDTH-1:0] r_drop;
    logic [31:0]          r_end_pc;
    logic                 r_ovf;

    logic       w_clr;
    logic       w_run;
    logic       w_sentinel;
    logic       w_last;
    logic       w_push;
    logic       w_pop;
    logic       w_drop;
    logic       w_full;
    logic       w_empty;
    logic       w_misalign;
    trc_entry_t w_in;
    trc_entry_t w_head;

    assign w_clr      = reset | start;
    assign w_run      = (r_state == ST_RUN);
    assign w_sentinel = w_run & retire_valid & (retire_instr == END_SENTINEL);
    assign w_last     = w_run & (r_cyc == CNT_WIDTH'(MAX_CYCLES - 1));
    assign w_push     = w_run & mem_write;
    assign w_pop      = ~w_empty & trc.trc_ready;
    assign w_drop     = w_push & w_full & ~w_pop;

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = ST_RUN;
        end else if (w_run) begin
            // A sentinel on the final budget cycle still counts as a clean halt
            if (w_sentinel)  w_state_nxt = ST_DONE;
            else if (w_last) w_state_nxt = ST_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_cyc    <= '0;
            r_instr  <= '0;
            r_store  <= '0;
            r_drop   <= '0;
            r_end_pc <= '0;
            r_ovf    <= 1'b0;
        end else if (w_run) begin
            if (~&r_cyc)
                r_cyc <= r_cyc + CNT_WIDTH'(1);
            if (retire_valid && ~&r_instr)
                r_instr <= r_instr + CNT_WIDTH'(1);
            if (w_sentinel)
                r_end_pc <= retire_pc;
            if (mem_write && ~&r_store)
                r_store <= r_store + CNT_WIDTH'(1);
            if (w_drop && ~&r_drop)
                r_drop <= r_drop + CNT_WIDTH'(1);
            if (w_drop)
                r_ovf <= 1'b1;
        end
    end

`ifdef CPU_PERF_MISALIGN_EN
    logic [CNT_WIDTH-1:0] r_mis;

    assign w_misalign = is_misaligned(dmem_addr);

    always_ff @(posedge clk) begin
        if (w_clr)
            r_mis <= '0;
        else if (w_push && w_misalign && ~&r_mis)
            r_mis <= r_mis + CNT_WIDTH'(1);
    end

    assign misalign_count = r_mis;
`else
    assign w_misalign     = 1'b0;
    assign misalign_count = '0;
`endif

    assign w_in = '{addr: dmem_addr, data: store_data, misalign: w_misalign};

    cpu_perf_fifo #(
        .WIDTH ($bits(trc_entry_t)),
        .DEPTH (TRACE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Payload is zeroed while empty so stale slots never leak out
    assign trc.trc_valid    = ~w_empty;
    assign trc.trc_addr     = w_empty ? 32'd0 : w_head.addr;
    assign trc.trc_data     = w_empty ? 32'd0 : w_head.data;
    assign trc.trc_misalign = ~w_empty & w_head.misalign;

    assign cycle_count = r_cyc;
    assign instr_count = r_instr;
    assign store_count = r_store;
    assign drop_count  = r_drop;
    assign end_pc      = r_end_pc;
    assign state       = r_state;
    assign done        = (r_state == ST_DONE);
    assign timeout     = (r_state == ST_TIMEOUT);
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_cpu_perf_monitor.sv
// Scoreboard bench for cpu_perf_monitor: stimulus queues expectations,
// a negedge monitor pops and compares trace beats and status snapshots.
module tb_cpu_perf_monitor;
    import cpu_perf_pkg::*;

`ifdef CPU_PERF_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    localparam int F_STATE = 0;
    localparam int F_CYC   = 1;
    localparam int F_INSTR = 2;
    localparam int F_STORE = 3;
    localparam int F_DROP  = 4;
    localparam int F_MIS   = 5;
    localparam int F_ENDPC = 6;
    localparam int F_DONE  = 7;
    localparam int F_TMO   = 8;
    localparam int F_OVF   = 9;
    localparam int F_TVAL  = 10;

    typedef struct {
        string       name;
        int          id;
        logic [31:0] exp;
    } st_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        retire_valid = 1'b0;
    logic [31:0] retire_pc = '0;
    logic [31:0] retire_instr = '0;
    logic        mem_write = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [31:0] store_data = '0;
    logic [31:0] cycle_count, instr_count, store_count;
    logic [31:0] drop_count, misalign_count, end_pc;
    logic [1:0]  state;
    logic        done, timeout, overflow;

    cpu_perf_if dif();

    cpu_perf_monitor dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .retire_valid   (retire_valid),
        .retire_pc      (retire_pc),
        .retire_instr   (retire_instr),
        .mem_write      (mem_write),
        .dmem_addr      (dmem_addr),
        .store_data     (store_data),
        .trc            (dif),
        .cycle_count    (cycle_count),
        .instr_count    (instr_count),
        .store_count    (store_count),
        .drop_count     (drop_count),
        .misalign_count (misalign_count),
        .end_pc         (end_pc),
        .state          (state),
        .done           (done),
        .timeout        (timeout),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    trc_entry_t sb_trc[$];
    st_t        sb_st[$];
    int         n_chk = 0;
    int         n_err = 0;
    bit         end_req = 1'b0;
    bit         fin = 1'b0;
    trc_entry_t m_e;
    st_t        m_s;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] field(input int id);
        case (id)
            F_STATE: return {30'd0, state};
            F_CYC:   return cycle_count;
            F_INSTR: return instr_count;
            F_STORE: return store_count;
            F_DROP:  return drop_count;
            F_MIS:   return misalign_count;
            F_ENDPC: return end_pc;
            F_DONE:  return {31'd0, done};
            F_TMO:   return {31'd0, timeout};
            F_OVF:   return {31'd0, overflow};
            F_TVAL:  return {31'd0, dif.trc_valid};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: trace beats are consumed whenever the handshake completes
    always @(negedge clk) begin
        if (!(reset || start) && dif.trc_valid && dif.trc_ready) begin
            if (sb_trc.size() == 0) begin
                cmp("trc_unexpected_addr", dif.trc_addr, 32'hFFFF_FFFF);
            end else begin
                m_e = sb_trc.pop_front();
                cmp("trc_addr", dif.trc_addr, m_e.addr);
                cmp("trc_data", dif.trc_data, m_e.data);
                cmp("trc_misalign", {31'd0, dif.trc_misalign},
                    {31'd0, m_e.misalign});
            end
        end
        while (sb_st.size() > 0) begin
            m_s = sb_st.pop_front();
            cmp(m_s.name, field(m_s.id), m_s.exp);
        end
        if (end_req && !fin) begin
            cmp("trc_leftover", sb_trc.size(), 32'd0);
            fin = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string n, input int id, input logic [31:0] v);
        sb_st.push_back('{name: n, id: id, exp: v});
    endtask

    task automatic exp_trc(input logic [31:0] a, input logic [31:0] d);
        sb_trc.push_back('{addr: a, data: d,
                           misalign: MIS_EN && (a[1:0] != 2'b00)});
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        st({tag, "_state"}, F_STATE, 32'd0);
        st({tag, "_cyc"}, F_CYC, 32'd0);
        st({tag, "_instr"}, F_INSTR, 32'd0);
        st({tag, "_store"}, F_STORE, 32'd0);
        st({tag, "_drop"}, F_DROP, 32'd0);
        st({tag, "_mis"}, F_MIS, 32'd0);
        st({tag, "_endpc"}, F_ENDPC, 32'd0);
        st({tag, "_done"}, F_DONE, 32'd0);
        st({tag, "_tmo"}, F_TMO, 32'd0);
        st({tag, "_ovf"}, F_OVF, 32'd0);
        st({tag, "_tval"}, F_TVAL, 32'd0);
    endtask

    initial begin
        dif.trc_ready = 1'b0;

        // Reset state
        tick();
        reset = 1'b0;
        chk_cleared("rst");

        // Three retires then sentinel at 0xC
        start_run();
        retire_valid = 1'b1;
        retire_instr = 32'h0000_0013;
        for (int i = 0; i < 3; i++) begin
            retire_pc = 32'(i * 4);
            tick();
        end
        retire_pc = 32'h0000_000C;
        retire_instr = 32'h0000_006F;
        tick();
        retire_valid = 1'b0;
        retire_instr = '0;
        st("halt_state", F_STATE, 32'd2);
        st("halt_instr", F_INSTR, 32'd4);
        st("halt_endpc", F_ENDPC, 32'h0000_000C);
        st("halt_done", F_DONE, 32'd1);
        st("halt_cyc", F_CYC, 32'd4);
        st("halt_tmo", F_TMO, 32'd0);

        // Inputs ignored outside RUN
        retire_valid = 1'b1;
        retire_instr = 32'h0000_0013;
        mem_write = 1'b1;
        dmem_addr = 32'h40;
        tick();
        retire_valid = 1'b0;
        mem_write = 1'b0;
        st("frozen_instr", F_INSTR, 32'd4);
        st("frozen_cyc", F_CYC, 32'd4);
        st("frozen_store", F_STORE, 32'd0);
        st("frozen_tval", F_TVAL, 32'd0);

        // Timeout after MAX_CYCLES run cycles
        start_run();
        st("restart_done", F_DONE, 32'd0);
        st("restart_endpc", F_ENDPC, 32'd0);
        repeat (19) tick();
        st("pre_tmo_state", F_STATE, 32'd1);
        st("pre_tmo_cyc", F_CYC, 32'd19);
        tick();
        st("tmo_state", F_STATE, 32'd3);
        st("tmo_cyc", F_CYC, 32'd20);
        st("tmo_flag", F_TMO, 32'd1);
        st("tmo_done", F_DONE, 32'd0);
        tick();
        st("tmo_frozen_cyc", F_CYC, 32'd20);

        // Sentinel on the last budget cycle wins
        start_run();
        repeat (19) tick();
        retire_valid = 1'b1;
        retire_instr = 32'h0000_006F;
        retire_pc = 32'h50;
        tick();
        retire_valid = 1'b0;
        st("race_state", F_STATE, 32'd2);
        st("race_cyc", F_CYC, 32'd20);
        st("race_endpc", F_ENDPC, 32'h50);
        st("race_instr", F_INSTR, 32'd1);

        // Single store, ready high, no bypass
        start_run();
        dif.trc_ready = 1'b1;
        mem_write = 1'b1;
        dmem_addr = 32'h20;
        store_data = 32'hC0DE_CAFE;
        exp_trc(32'h20, 32'hC0DE_CAFE);
        st("nobypass_tval", F_TVAL, 32'd0);
        tick();
        mem_write = 1'b0;
        st("st1_tval", F_TVAL, 32'd1);
        st("st1_store", F_STORE, 32'd1);
        tick();
        st("st1_drained", F_TVAL, 32'd0);

        // Misaligned store
        start_run();
        mem_write = 1'b1;
        dmem_addr = 32'h22;
        store_data = 32'h1234;
        exp_trc(32'h22, 32'h1234);
        tick();
        mem_write = 1'b0;
        st("mis_count", F_MIS, {31'd0, MIS_EN});
        st("mis_store", F_STORE, 32'd1);
        tick();

        // Overflow: ten stores into depth eight
        start_run();
        dif.trc_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_write = 1'b1;
            dmem_addr = 32'h100 + 32'(i * 4);
            store_data = 32'(i);
            if (i < 8) exp_trc(dmem_addr, store_data);
            tick();
        end
        mem_write = 1'b0;
        st("ovf_store", F_STORE, 32'd10);
        st("ovf_drop", F_DROP, 32'd2);
        st("ovf_flag", F_OVF, 32'd1);
        st("ovf_tval", F_TVAL, 32'd1);
        tick();
        // Push and pop together while full
        dif.trc_ready = 1'b1;
        mem_write = 1'b1;
        dmem_addr = 32'h200;
        store_data = 32'h0000_AAAA;
        exp_trc(32'h200, 32'h0000_AAAA);
        tick();
        mem_write = 1'b0;
        st("full_pp_drop", F_DROP, 32'd2);
        st("full_pp_store", F_STORE, 32'd11);
        repeat (8) tick();
        st("ovf_drained", F_TVAL, 32'd0);
        st("ovf_sticky", F_OVF, 32'd1);

        // Reset mid-run with three queued entries
        dif.trc_ready = 1'b0;
        start_run();
        retire_valid = 1'b1;
        retire_instr = 32'h0000_0013;
        for (int i = 0; i < 3; i++) begin
            mem_write = 1'b1;
            dmem_addr = 32'h300 + 32'(i * 4);
            tick();
        end
        mem_write = 1'b0;
        retire_valid = 1'b0;
        st("mid_store", F_STORE, 32'd3);
        st("mid_instr", F_INSTR, 32'd3);
        st("mid_tval", F_TVAL, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_cleared("midrst");
        dif.trc_ready = 1'b1;
        tick();
        st("midrst_still_empty", F_TVAL, 32'd0);

        // Reset beats start
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        st("rst_over_start", F_STATE, 32'd0);
        tick();

        end_req = 1'b1;
        for (int i = 0; i < 10 && !fin; i++) @(posedge clk);
        if (!fin) begin
            $display("FAIL monitor_stall: fin=%0d want 1", fin);
            $fatal(1);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
